// File: rtl/reg_scoreboard_if.sv
// Issue/retire/query bundle between decode, write-back and the register scoreboard.
interface reg_scoreboard_if #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5
);
   logic            flush;
   logic            issue_valid;
   logic            issue_we;
   logic [AW-1:0]   issue_dst;
   logic [AW-1:0]   rs_addr;
   logic            rs_used;
   logic [AW-1:0]   rt_addr;
   logic            rt_used;
   logic            stall;
   logic            retire_valid;
   logic [AW-1:0]   retire_dst;
   logic [NREG-1:0] busy_vec;
   logic [5:0]      inflight_cnt;
   logic            err;

   modport master (
      output flush, issue_valid, issue_we, issue_dst, rs_addr, rs_used, rt_addr, rt_used,
      output retire_valid, retire_dst,
      input  stall, busy_vec, inflight_cnt, err
   );

   modport slave (
      input  flush, issue_valid, issue_we, issue_dst, rs_addr, rs_used, rt_addr, rt_used,
      input  retire_valid, retire_dst,
      output stall, busy_vec, inflight_cnt, err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters; raises stall on RAW hazards or counter saturation.
module reg_scoreboard #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned CW   = 2
) (
   input logic              clk,
   input logic              rst,
   reg_scoreboard_if.slave  sb
);
   localparam logic [CW-1:0] CMAX = '1;

   logic [CW-1:0]   cnt_q [NREG];
   logic [CW-1:0]   cnt_d [NREG];
   logic [5:0]      infl_q, infl_d;
   logic            err_q, err_d;
   logic [NREG-1:0] eff_busy;
   logic [NREG-1:0] busy;
   logic            sat_block, stall_c, inc, ret, dec, same_reg;

   // A same-cycle retire of the register clears the hazard (write-through register file).
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         eff_busy[r] = (r != 0) &&
                       (cnt_q[r] > CW'(sb.retire_valid && (sb.retire_dst == AW'(r))));
      end
   end

   assign sat_block = sb.issue_we && (sb.issue_dst != '0) && (cnt_q[sb.issue_dst] == CMAX) &&
                      !(sb.retire_valid && (sb.retire_dst == sb.issue_dst));

   assign stall_c = !rst && !sb.flush && sb.issue_valid &&
                    ((sb.rs_used && eff_busy[sb.rs_addr]) ||
                     (sb.rt_used && eff_busy[sb.rt_addr]) || sat_block);

   assign inc      = sb.issue_valid && !stall_c && !sb.flush && sb.issue_we &&
                     (sb.issue_dst != '0);
   assign ret      = sb.retire_valid && (sb.retire_dst != '0);
   assign dec      = ret && (cnt_q[sb.retire_dst] != '0);
   assign same_reg = sb.issue_dst == sb.retire_dst;

   always_comb begin
      cnt_d  = cnt_q;
      infl_d = infl_q;
      err_d  = err_q;
      if (sb.flush) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = '0;
         end
         infl_d = '0;
      end else begin
         if (ret && !dec) begin
            err_d = 1'b1;
         end
         if (!(inc && dec && same_reg)) begin
            if (inc) begin
               if (cnt_q[sb.issue_dst] == CMAX) begin
                  err_d = 1'b1;
               end else begin
                  cnt_d[sb.issue_dst] = cnt_q[sb.issue_dst] + CW'(1);
                  infl_d              = infl_q + 6'd1;
               end
            end
            if (dec) begin
               cnt_d[sb.retire_dst] = cnt_q[sb.retire_dst] - CW'(1);
               infl_d               = infl_d - 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         infl_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         infl_q <= infl_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         busy[r] = cnt_q[r] != '0;
      end
   end

   assign sb.busy_vec     = busy;
   assign sb.inflight_cnt = infl_q;
   assign sb.err          = err_q;
   assign sb.stall        = stall_c;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a per-cycle count-table model and literal pins.
module tb_reg_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   reg_scoreboard_if #(.NREG(32), .AW(5)) sb_if ();

   reg_scoreboard #(.NREG(32), .AW(5), .CW(2)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: plain count table, updated from the inputs seen just before each rising edge.
   int mcnt [32];
   bit merr = 1'b0;

   function automatic bit eff_busy_m(input int r);
      int pend;
      pend = mcnt[r];
      if (sb_if.retire_valid && int'(sb_if.retire_dst) == r) pend = pend - 1;
      return (r != 0) && (pend > 0);
   endfunction

   initial begin
      int  nxt [32];
      int  sum;
      int  d, q;
      bit  exp_stall;
      logic [31:0] exp_busy;
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
            merr = 1'b0;
         end
         d = int'(sb_if.issue_dst);
         q = int'(sb_if.retire_dst);
         exp_stall = !rst && !sb_if.flush && sb_if.issue_valid &&
                     ((sb_if.rs_used && eff_busy_m(int'(sb_if.rs_addr))) ||
                      (sb_if.rt_used && eff_busy_m(int'(sb_if.rt_addr))) ||
                      (sb_if.issue_we && d != 0 && mcnt[d] == 3 &&
                       !(sb_if.retire_valid && q == d)));
         sum = 0;
         for (int i = 0; i < 32; i++) begin
            exp_busy[i] = mcnt[i] != 0;
            sum += mcnt[i];
         end
         chk("model_busy_vec", sb_if.busy_vec, exp_busy);
         chk("model_inflight", sb_if.inflight_cnt, sum % 64);
         chk("model_err", sb_if.err, merr);
         chk("model_stall", sb_if.stall, exp_stall);
         if (!rst) begin
            nxt = mcnt;
            if (sb_if.flush) begin
               for (int i = 0; i < 32; i++) nxt[i] = 0;
            end else begin
               if (sb_if.issue_valid && !exp_stall && sb_if.issue_we && d != 0) nxt[d]++;
               if (sb_if.retire_valid && q != 0) begin
                  if (mcnt[q] == 0) merr = 1'b1;
                  else nxt[q]--;
               end
               for (int i = 0; i < 32; i++) begin
                  if (nxt[i] > 3) begin
                     merr = 1'b1;
                     nxt[i] = 3;
                  end
               end
            end
            mcnt = nxt;
         end
      end
   end

   task automatic drive(input logic iv, input logic we, input logic [4:0] dst,
                        input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu,
                        input logic rv, input logic [4:0] rdst, input logic fl);
      sb_if.issue_valid  = iv;
      sb_if.issue_we     = we;
      sb_if.issue_dst    = dst;
      sb_if.rs_addr      = rs;
      sb_if.rs_used      = rsu;
      sb_if.rt_addr      = rt;
      sb_if.rt_used      = rtu;
      sb_if.retire_valid = rv;
      sb_if.retire_dst   = rdst;
      sb_if.flush        = fl;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      idle();
      step();
      step();
      rst = 1'b0;

      // Underflow on an empty register
      drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
      step();
      chk("underflow_err", sb_if.err, 1);
      chk("underflow_busy", sb_if.busy_vec, 0);

      // Two writes pending to r8, then asynchronous reset mid-run
      drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("r8_inflight", sb_if.inflight_cnt, 2);
      chk("r8_busy", sb_if.busy_vec[8], 1);
      rst = 1'b1;
      drive(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
      chk("rst_busy", sb_if.busy_vec, 0);
      chk("rst_inflight", sb_if.inflight_cnt, 0);
      chk("rst_err", sb_if.err, 0);
      chk("rst_stall", sb_if.stall, 0);
      step();
      rst = 1'b0;

      // RAW hazard on r9, cleared by a same-cycle retire
      drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      chk("raw_stall", sb_if.stall, 1);
      step();
      drive(1, 0, 0, 9, 1, 0, 0, 1, 9, 0);
      chk("raw_bypass_stall", sb_if.stall, 0);
      step();
      chk("raw_busy9", sb_if.busy_vec[9], 0);
      chk("raw_inflight", sb_if.inflight_cnt, 0);

      // Saturation of r5
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
         step();
      end
      chk("sat_inflight", sb_if.inflight_cnt, 3);
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      chk("sat_stall", sb_if.stall, 1);
      step();
      chk("sat_hold", sb_if.inflight_cnt, 3);
      drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
      chk("sat_retire_stall", sb_if.stall, 0);
      step();
      chk("sat_retire_inflight", sb_if.inflight_cnt, 3);
      chk("sat_retire_busy5", sb_if.busy_vec[5], 1);
      chk("sat_err_clear", sb_if.err, 0);

      // Issue r4 while retiring r7
      drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("sim_pre_inflight", sb_if.inflight_cnt, 4);
      drive(1, 1, 4, 0, 0, 0, 0, 1, 7, 0);
      chk("sim_stall", sb_if.stall, 0);
      step();
      chk("sim_busy4", sb_if.busy_vec[4], 1);
      chk("sim_busy7", sb_if.busy_vec[7], 0);
      chk("sim_inflight", sb_if.inflight_cnt, 4);
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
      chk("rt_stall", sb_if.stall, 1);
      step();

      // Underflow stickiness and register 0
      drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
      step();
      chk("err_set", sb_if.err, 1);
      drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      step();
      chk("r0_inflight", sb_if.inflight_cnt, 4);
      chk("r0_err", sb_if.err, 1);
      chk("r0_busy", sb_if.busy_vec[0], 0);
      drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      chk("r0_stall", sb_if.stall, 0);
      step();

      // Flush with an issue pending
      drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("pre_flush_inflight", sb_if.inflight_cnt, 7);
      drive(1, 1, 10, 3, 1, 0, 0, 0, 0, 1);
      chk("flush_stall", sb_if.stall, 0);
      step();
      chk("flush_busy", sb_if.busy_vec, 0);
      chk("flush_inflight", sb_if.inflight_cnt, 0);
      chk("flush_err", sb_if.err, 1);
      idle();
      step();
      chk("post_flush_busy", sb_if.busy_vec, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Read-side companion to the write-destination select path. Tracks which architectural registers have writes in flight: the selected destination register number (rt, rd or 31) is issued in, and retired at write-back.
- Answers decode-stage source-operand queries (rs, rt) and raises a stall while a source register is still pending.
- Sits between decode/issue and write-back of the multi-cycle/pipelined CPU core.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width.
- CW, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^CW-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all pending state (pipeline squash)
- issue_valid  input  1  decode presents an instruction this cycle
- issue_we  input  1  instruction writes a register
- issue_dst  input  AW  destination register (output of destination select)
- rs_addr  input  AW  source register A
- rs_used  input  1  instruction reads rs
- rt_addr  input  AW  source register B
- rt_used  input  1  instruction reads rt
- stall  output  1  combinational; issue not accepted this cycle
- retire_valid  input  1  write-back completes a register write
- retire_dst  input  AW  register being written back
- busy_vec  output  NREG  registered; bit i = counter[i] != 0
- inflight_cnt  output  6  registered; total pending writes across all registers
- err  output  1  registered, sticky; underflow (retire with zero count) or overflow attempt

Behaviour:
- State: NREG counters of CW bits, inflight_cnt, err. rst asserted (any time, incl. mid-operation): all counters, busy_vec, inflight_cnt and err = 0 immediately; stall = 0 while rst is high.
- Effective busy of register r in the current cycle: counter[r] minus (retire_valid && retire_dst==r) > 0. A same-cycle retire therefore clears the hazard (register file is write-through).
- Register 0: never busy. Issues to 0 are ignored. Retires to 0 are ignored and do not set err.
- stall = issue_valid && ( (rs_used && effbusy[rs_addr]) || (rt_used && effbusy[rt_addr]) || (issue_we && issue_dst!=0 && counter[issue_dst]==2^CW-1 && !(retire_valid && retire_dst==issue_dst)) ).
- Accept = issue_valid && !stall && !flush. If accepted and issue_we and issue_dst!=0: counter[issue_dst] += 1 at next edge.
- Retire: if retire_valid and retire_dst!=0:
  - counter[retire_dst] != 0: decrement it.
  - counter[retire_dst] == 0: counter holds at 0 and err <= 1.
- Same-cycle issue and retire:
  - Same register: net counter change 0.
  - Different registers: both updates apply.
- inflight_cnt tracks the sum of all counters and is updated with the same net rule.
- Overflow never silently wraps. Saturation forces stall. err is also set if a saturated increment would occur, which can only happen through a design-rule violation.
- flush (synchronous, priority over issue and retire): all counters and inflight_cnt <= 0 at next edge; err is unchanged. stall is forced to 0 during flush.
- busy_vec and inflight_cnt reflect post-edge state: one-cycle latency after the issue or retire edge.

Test Plan:
- Reset: assert rst mid-run with counter[8]=2 -> busy_vec=0, inflight_cnt=0, err=0 immediately; stall=0.
- RAW hazard: issue we dst=9, next cycle issue rs=9 rs_used=1 -> stall=1. Retire 9 in the same cycle -> stall=0, busy_vec[9]=0 after the edge.
- Saturation: three accepted issues to dst=5 (counter=3), fourth issue to 5 -> stall=1, counter stays 3. Same fourth issue with concurrent retire_dst=5 -> accepted, counter stays 3.
- Simultaneous events: issue dst=4 and retire dst=7 (counter[7]=1) in one cycle -> counter[4]=1, counter[7]=0, inflight_cnt unchanged.
- Underflow and register 0: retire dst=12 with counter 0 -> err=1 sticky, counter 0. Issue or retire dst=0 -> no state change, err unaffected. rs_addr=0 never stalls.
- Flush: counters {3:2, 9:1}, flush=1 with issue_valid=1 -> next cycle busy_vec=0, inflight_cnt=0, no issue recorded, err unchanged.
